// File: rtl/lut_btb.sv
// Programmable branch-target table: pointer selects an absolute target or a PC-relative offset.
// One-cycle registered lookup; self-initialises to PC+DEFAULT_TGT via a post-reset sweep.
module lut_btb #(
  parameter int PC_width    = 10,
  parameter int ADDR_W      = 4,
  parameter int DEFAULT_TGT = 1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  output logic                ready,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [PC_width-1:0] wr_data,
  input  logic                wr_rel,
  input  logic                rd_req,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic [PC_width-1:0] pc_in,
  output logic                rd_valid,
  output logic [PC_width-1:0] target
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0]   LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [PC_width-1:0] DEF_DATA = PC_width'(DEFAULT_TGT);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q, state_d;
  logic   [ADDR_W-1:0]   init_ptr;
  logic   [PC_width:0]   entries [DEPTH];

  logic                  sel_rel;
  logic   [PC_width-1:0] sel_data;

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && init_ptr == LAST_PTR) state_d = S_RUN;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= S_INIT;
      init_ptr <= '0;
      ready    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready   <= (state_d == S_RUN);
      if (state_q == S_INIT && init_ptr != LAST_PTR) init_ptr <= init_ptr + ADDR_W'(1);
    end
  end

  // Storage is deliberately not reset; the INIT sweep restores defaults.
  always_ff @(posedge Clk) begin
    if (Reset_n) begin
      if (state_q == S_INIT) entries[init_ptr] <= {1'b1, DEF_DATA};
      else if (wr_en && ready) entries[wr_addr] <= {wr_rel, wr_data};
    end
  end

  // Write-first bypass when a same-cycle write hits the entry being read.
  always_comb begin
    sel_rel  = entries[rd_addr][PC_width];
    sel_data = entries[rd_addr][PC_width-1:0];
    if (wr_en && wr_addr == rd_addr) begin
      sel_rel  = wr_rel;
      sel_data = wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rd_valid <= 1'b0;
      target   <= '0;
    end else if (rd_req && ready) begin
      rd_valid <= 1'b1;
      target   <= sel_rel ? pc_in + sel_data : sel_data;
    end else begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: doc/lut_btb.md
Name: lut_btb

Overview:
- Programmable branch-target table. It is the parametrised successor to the fixed 16-entry PC-target lookup.
- A short pointer from the instruction selects an entry. The entry yields either an absolute PC target or a signed PC-relative offset that is added to the current PC.
- Entries are writable at run time. The table self-initialises after reset through a sequential INIT sweep.
- Sits between the decoder (pointer and PC) and the fetch unit's next-PC mux.

Parameters:
- PC_width, 10, width of PC, targets and stored entry data.
- ADDR_W, 4, pointer width; DEPTH = 2**ADDR_W entries.
- DEFAULT_TGT, 1, data loaded into every entry at init. It is loaded as relative, so the default behaviour is PC+1.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset_n  input  1  reset, synchronous, active-low.
- ready  output  1  high when table is in RUN and accepts reads and writes.
- wr_en  input  1  write strobe; honoured only when ready=1.
- wr_addr  input  ADDR_W  entry to write.
- wr_data  input  PC_width  absolute target or two's-complement offset.
- wr_rel  input  1  1 = entry is relative, 0 = absolute.
- rd_req  input  1  lookup request; honoured only when ready=1.
- rd_addr  input  ADDR_W  entry pointer.
- pc_in  input  PC_width  current PC, sampled with rd_req.
- rd_valid  output  1  one-cycle pulse, target valid.
- target  output  PC_width  computed branch target.

Behaviour:
- Storage: DEPTH entries of {rel, data[PC_width-1:0]}, implemented in flops.
- Reset (Reset_n sampled low at an edge):
  - state=INIT, init_ptr=0.
  - ready=0, rd_valid=0, target=0.
  - Entry contents are not cleared by reset itself.
- INIT state:
  - Each edge with Reset_n high writes entry[init_ptr] = {rel=1, data=DEFAULT_TGT}, then init_ptr increments.
  - The first edge with Reset_n high writes entry 0. The edge that writes entry DEPTH-1 moves state to RUN.
  - ready is registered. It reads 1 from the cycle after the DEPTH-th init edge; it reads 0 during all earlier cycles.
  - wr_en and rd_req are ignored while ready=0: no write, no rd_valid.
- RUN state:
  - Remains in RUN until Reset_n is sampled low.
- Write:
  - wr_en & ready at an edge updates entry[wr_addr] = {wr_rel, wr_data] at that edge.
- Read (latency 1 cycle, registered output):
  - rd_req & ready at edge N gives rd_valid=1 and target valid after edge N.
  - Absolute entry: target = data.
  - Relative entry: target = (pc_in + data) mod 2**PC_width. data is treated as signed PC_width, so no sign extension is needed at equal width. Example: 'h3FC is -4.
  - Back-to-back requests are supported: rd_valid stays high on consecutive cycles, with a new target each cycle.
  - When no request is accepted, rd_valid=0 and target holds its last value.
- Simultaneous write and read, same address, same edge:
  - Write-first bypass: target is computed from {wr_rel, wr_data}, not the old entry.
  - Different addresses are independent.
- Reset mid-operation:
  - Reset_n low at any edge aborts all activity: rd_valid=0 after that edge, and any pending or in-progress write is dropped.
  - A full INIT sweep reruns, and all user-written entries revert to default.
  - Reset asserted during INIT restarts the sweep at init_ptr=0.
- Pointer wrap:
  - init_ptr stops at DEPTH-1; it never wraps.
  - rd_addr and wr_addr span the full range; there are no out-of-range values.

Test Plan:
1. Init timing/default: release Reset_n (DEPTH=16).
   - ready=0 for 16 cycles, then 1.
   - Then rd_req addr 5, pc_in='h008 gives rd_valid=1 next cycle, target='h009.
2. Absolute entry: write addr 2, data='h034, rel=0. Read addr 2 with pc_in='h100 gives target='h034.
3. Relative negative and wrap: write addr 3, data='h3FC, rel=1.
   - pc_in='h008 gives target='h004.
   - pc_in='h002 gives target='h3FE.
   - Back-to-back reads give rd_valid high two cycles.
4. Same-address bypass: in one cycle, wr_en addr 7 data='h022 rel=0, and rd_req addr 7. Next cycle target='h022, not the default PC+1.
5. Requests during INIT: hold rd_req=1 and wr_en=1 (addr 0, 'h3FF) throughout INIT.
   - No rd_valid until ready=1.
   - After ready, read addr 0 with pc_in='h010 gives 'h011 (the INIT-time write was dropped).
6. Reset mid-run:
   - After tests 2–4, assert Reset_n low for one cycle coincident with rd_req. Next cycle rd_valid=0 and ready=0; ready returns 16 cycles later.
   - Then read addr 2 with pc_in='h020 gives 'h021.
